// File: rtl/stream_bank_responder.sv
// stream_bank_responder: per-bank round-robin arbitration of one stream's AGE
// requests onto registered single-port SRAM bank strobes, with load data return.
module stream_bank_responder #(
  parameter int N_AGE     = 4,
  parameter int N_BANKS   = 4,
  parameter int NBIT_ADDR = 12,
  parameter int NBIT_DATA = 32,
  parameter int NBIT_CNT  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_AGE-1:0]               age_valid_i,
  input  logic [N_AGE-1:0]               age_lns_i,
  input  logic [N_AGE*NBIT_ADDR-1:0]     age_addr_i,
  input  logic [N_AGE*N_BANKS-1:0]       age_bank_i,
  input  logic [N_AGE*NBIT_DATA-1:0]     age_wdata_i,
  output logic [N_AGE-1:0]               age_gnt_o,
  output logic [N_AGE-1:0]               age_rvalid_o,
  output logic [N_AGE*NBIT_DATA-1:0]     age_rdata_o,
  output logic [N_BANKS-1:0]             bank_req_o,
  output logic [N_BANKS-1:0]             bank_we_o,
  output logic [N_BANKS*NBIT_ADDR-1:0]   bank_addr_o,
  output logic [N_BANKS*NBIT_DATA-1:0]   bank_wdata_o,
  input  logic [N_BANKS*NBIT_DATA-1:0]   bank_rdata_i,
  input  logic                           cnt_clear_i,
  output logic [NBIT_CNT-1:0]            conflict_cnt_o,
  output logic                           bank_err_o
);

  localparam int PW = (N_AGE > 1) ? $clog2(N_AGE) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_AGE - 1);

  logic [N_BANKS-1:0]   bank_of  [N_AGE];
  logic [NBIT_ADDR-1:0] addr_of  [N_AGE];
  logic [NBIT_DATA-1:0] wdata_of [N_AGE];
  logic [N_AGE-1:0]     elig;
  logic [N_AGE-1:0]     bad;

  for (genvar a = 0; a < N_AGE; a++) begin : g_age
    logic onehot;
    assign bank_of[a]  = age_bank_i[a*N_BANKS +: N_BANKS];
    assign addr_of[a]  = age_addr_i[a*NBIT_ADDR +: NBIT_ADDR];
    assign wdata_of[a] = age_wdata_i[a*NBIT_DATA +: NBIT_DATA];
    assign onehot = (bank_of[a] != '0) &&
                    ((bank_of[a] & (bank_of[a] - 1'b1)) == '0);
    assign elig[a] = age_valid_i[a] & onehot;
    assign bad[a]  = age_valid_i[a] & ~onehot;
  end

  logic [PW-1:0]      ptr     [N_BANKS];
  logic [PW-1:0]      win_idx [N_BANKS];
  logic [N_BANKS-1:0] win_v;
  logic [N_AGE-1:0]   gnt;
  logic [PW-1:0]      scan;
  logic               denied;

  // Scan N_AGE slots starting at ptr; wrap is an explicit compare.
  always_comb begin
    win_v = '0;
    gnt   = '0;
    scan  = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      win_idx[b] = '0;
      scan = ptr[b];
      for (int k = 0; k < N_AGE; k++) begin
        if (!win_v[b] && elig[scan] && bank_of[scan][b]) begin
          win_v[b]   = 1'b1;
          win_idx[b] = scan;
        end
        scan = (scan == LAST) ? '0 : scan + 1'b1;
      end
      if (win_v[b]) gnt[win_idx[b]] = 1'b1;
    end
  end

  assign age_gnt_o = gnt;
  assign denied    = |(elig & ~gnt);

  logic [N_BANKS-1:0] t1_v;
  logic [N_BANKS-1:0] t2_v;
  logic [PW-1:0]      t1_idx [N_BANKS];
  logic [PW-1:0]      t2_idx [N_BANKS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < N_BANKS; b++) begin
        ptr[b]    <= '0;
        t1_idx[b] <= '0;
        t2_idx[b] <= '0;
      end
      bank_req_o     <= '0;
      bank_we_o      <= '0;
      bank_addr_o    <= '0;
      bank_wdata_o   <= '0;
      t1_v           <= '0;
      t2_v           <= '0;
      conflict_cnt_o <= '0;
      bank_err_o     <= 1'b0;
    end else begin
      bank_req_o <= win_v;
      t2_v       <= t1_v;
      for (int b = 0; b < N_BANKS; b++) begin
        bank_we_o[b] <= win_v[b] & ~age_lns_i[win_idx[b]];
        t1_v[b]      <= win_v[b] & age_lns_i[win_idx[b]];
        t1_idx[b]    <= win_idx[b];
        t2_idx[b]    <= t1_idx[b];
        if (win_v[b]) begin
          ptr[b] <= (win_idx[b] == LAST) ? '0 : win_idx[b] + 1'b1;
          bank_addr_o[b*NBIT_ADDR +: NBIT_ADDR]  <= addr_of[win_idx[b]];
          bank_wdata_o[b*NBIT_DATA +: NBIT_DATA] <= wdata_of[win_idx[b]];
        end
      end
      if (cnt_clear_i)
        conflict_cnt_o <= '0;
      else if (denied && !(&conflict_cnt_o))
        conflict_cnt_o <= conflict_cnt_o + 1'b1;
      if (|bad) bank_err_o <= 1'b1;
    end
  end

  // Return path: the t+2 tag steers its bank's read data to the winner.
  always_comb begin
    age_rvalid_o = '0;
    age_rdata_o  = '0;
    for (int a = 0; a < N_AGE; a++) begin
      for (int b = 0; b < N_BANKS; b++) begin
        if (t2_v[b] && t2_idx[b] == PW'(a)) begin
          age_rvalid_o[a] = 1'b1;
          age_rdata_o[a*NBIT_DATA +: NBIT_DATA] =
            bank_rdata_i[b*NBIT_DATA +: NBIT_DATA];
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_bank_responder.sv
// tb_stream_bank_responder: directed stimulus, SRAM bank model and a
// cycle-level reference model of the responder checked every cycle.
module tb_stream_bank_responder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   age_valid_i;
  logic [3:0]   age_lns_i;
  logic [47:0]  age_addr_i;
  logic [15:0]  age_bank_i;
  logic [127:0] age_wdata_i;
  logic [3:0]   age_gnt_o;
  logic [3:0]   age_rvalid_o;
  logic [127:0] age_rdata_o;
  logic [3:0]   bank_req_o;
  logic [3:0]   bank_we_o;
  logic [47:0]  bank_addr_o;
  logic [127:0] bank_wdata_o;
  logic [127:0] bank_rdata_i;
  logic         cnt_clear_i;
  logic [15:0]  conflict_cnt_o;
  logic         bank_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  stream_bank_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .age_valid_i(age_valid_i), .age_lns_i(age_lns_i),
    .age_addr_i(age_addr_i), .age_bank_i(age_bank_i),
    .age_wdata_i(age_wdata_i), .age_gnt_o(age_gnt_o),
    .age_rvalid_o(age_rvalid_o), .age_rdata_o(age_rdata_o),
    .bank_req_o(bank_req_o), .bank_we_o(bank_we_o),
    .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o),
    .bank_rdata_i(bank_rdata_i), .cnt_clear_i(cnt_clear_i),
    .conflict_cnt_o(conflict_cnt_o), .bank_err_o(bank_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] pat(int b, int i);
    return 32'hA500_0000 | 32'(b << 16) | 32'(i);
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // SRAM banks: one-cycle read latency, contents preset to pat(b,i)
  logic [31:0] sram [4][4096];
  logic        sinit = 1'b0;
  always @(posedge clk_i) begin
    if (!sinit) begin
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 4096; i++) sram[b][i] <= pat(b, i);
      sinit <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bank_req_o[b]) begin
          if (bank_we_o[b])
            sram[b][bank_addr_o[b*12 +: 12]] <= bank_wdata_o[b*32 +: 32];
          else
            bank_rdata_i[b*32 +: 32] <= sram[b][bank_addr_o[b*12 +: 12]];
        end
    end
  end

  // Reference model: memory image, pointers, expected outputs per cycle
  logic [31:0]  mm [4][4096];
  int           mptr [4];
  logic [3:0]   e_req, e_we;
  logic [47:0]  e_addr;
  logic [127:0] e_wdata;
  logic [3:0]   rv_s [4];
  logic [127:0] rd_s [4];
  logic [15:0]  e_cnt;
  logic         e_err;
  int           cyc = 0;

  always @(negedge clk_i) begin
    logic [3:0] g, el;
    logic [3:0] bk;
    int w [4];
    int sl, a, ad;
    if (cyc == 0)
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 4096; i++) mm[b][i] = pat(b, i);
    if (rst_i) begin
      for (int b = 0; b < 4; b++) begin
        mptr[b] = 0;
        rv_s[b] = '0;
        rd_s[b] = '0;
      end
      e_req = '0; e_we = '0; e_addr = '0; e_wdata = '0;
      e_cnt = '0; e_err = 1'b0;
    end
    sl = cyc % 4;
    chk("bank_req", bank_req_o, e_req);
    chk("bank_we", bank_we_o, e_we);
    chk("bank_addr", bank_addr_o, e_addr);
    chk("bank_wdata", bank_wdata_o, e_wdata);
    chk("rvalid", age_rvalid_o, rv_s[sl]);
    chk("rdata", age_rdata_o, rd_s[sl]);
    chk("conflict_cnt", conflict_cnt_o, e_cnt);
    chk("bank_err", bank_err_o, e_err);
    g = '0;
    for (int i = 0; i < 4; i++) begin
      bk = age_bank_i[i*4 +: 4];
      el[i] = age_valid_i[i] && ($countones(bk) == 1);
    end
    for (int b = 0; b < 4; b++) begin
      w[b] = -1;
      for (int k = 0; k < 4; k++) begin
        a = (mptr[b] + k) % 4;
        if (w[b] < 0 && el[a] && age_bank_i[a*4 + b]) w[b] = a;
      end
      if (w[b] >= 0) g[w[b]] = 1'b1;
    end
    chk("gnt", age_gnt_o, g);
    rv_s[sl] = '0;
    rd_s[sl] = '0;
    if (!rst_i) begin
      e_req = '0;
      e_we  = '0;
      for (int b = 0; b < 4; b++) begin
        if (w[b] >= 0) begin
          a  = w[b];
          ad = int'(age_addr_i[a*12 +: 12]);
          e_req[b] = 1'b1;
          e_we[b]  = !age_lns_i[a];
          e_addr[b*12 +: 12]  = age_addr_i[a*12 +: 12];
          e_wdata[b*32 +: 32] = age_wdata_i[a*32 +: 32];
          if (age_lns_i[a]) begin
            rv_s[(cyc+2)%4][a] = 1'b1;
            rd_s[(cyc+2)%4][a*32 +: 32] = mm[b][ad];
          end else begin
            mm[b][ad] = age_wdata_i[a*32 +: 32];
          end
          mptr[b] = (a + 1) % 4;
        end
      end
      if (cnt_clear_i) e_cnt = '0;
      else if ((el & ~g) != 0 && e_cnt != 16'hFFFF) e_cnt = e_cnt + 1'b1;
      if ((age_valid_i & ~el) != 0) e_err = 1'b1;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    age_valid_i = '0;
    age_lns_i   = '0;
    cnt_clear_i = 1'b0;
  endtask

  task automatic drv(int a, logic l, logic [11:0] ad,
                     logic [3:0] bk, logic [31:0] wd);
    age_valid_i[a] = 1'b1;
    age_lns_i[a]   = l;
    age_addr_i[a*12 +: 12] = ad;
    age_bank_i[a*4 +: 4]   = bk;
    age_wdata_i[a*32 +: 32] = wd;
  endtask

  initial begin
    logic [3:0] eg;
    rst_i = 1'b1;
    idle();
    age_addr_i = '0; age_bank_i = '0; age_wdata_i = '0;
    repeat (2) step();
    #1;
    chk("rst_req", bank_req_o, 4'h0);
    chk("rst_cnt", conflict_cnt_o, 16'h0);
    chk("rst_err", bank_err_o, 1'b0);
    rst_i = 1'b0;
    step();

    // all four AGEs load bank 2: grants 0,1,2,3 in turn
    for (int a = 0; a < 4; a++) drv(a, 1'b1, 12'(32 + a), 4'b0100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      eg = 4'b0001 << k;
      chk("rr_gnt", age_gnt_o, eg);
      step();
      age_valid_i[k] = 1'b0;
    end
    #1;
    chk("rr_cnt", conflict_cnt_o, 16'd3);
    step();

    // no conflict: AGE a loads bank a at 0x10
    for (int a = 0; a < 4; a++) drv(a, 1'b1, 12'h010, 4'b0001 << a, 32'h0);
    #1;
    chk("nc_gnt", age_gnt_o, 4'hF);
    step();
    idle();
    #1;
    chk("nc_req", bank_req_o, 4'hF);
    chk("nc_we", bank_we_o, 4'h0);
    chk("nc_addr", bank_addr_o, 48'h010_010_010_010);
    step();
    #1;
    chk("nc_rvalid", age_rvalid_o, 4'hF);
    chk("nc_rdata", age_rdata_o,
        128'hA5030010_A5020010_A5010010_A5000010);
    step();

    // store then load of bank 1 addr 5 by AGE1
    drv(1, 1'b0, 12'h005, 4'b0010, 32'hDEADBEEF);
    #1;
    chk("st_gnt", age_gnt_o, 4'b0010);
    step();
    drv(1, 1'b1, 12'h005, 4'b0010, 32'h0);
    #1;
    chk("st_we", bank_we_o, 4'b0010);
    chk("st_wdata", bank_wdata_o[63:32], 32'hDEADBEEF);
    step();
    idle();
    #1;
    chk("ld_we", bank_we_o, 4'b0000);
    chk("ld_req", bank_req_o, 4'b0010);
    step();
    #1;
    chk("ld_rvalid", age_rvalid_o, 4'b0010);
    chk("ld_rdata", age_rdata_o[63:32], 32'hDEADBEEF);
    step();

    // multi-hot bank on AGE0; AGE1/AGE2 unaffected
    drv(0, 1'b1, 12'h000, 4'b0110, 32'h0);
    drv(1, 1'b1, 12'h007, 4'b0010, 32'h0);
    drv(2, 1'b1, 12'h008, 4'b0100, 32'h0);
    #1;
    chk("bad_gnt", age_gnt_o, 4'b0110);
    chk("bad_err0", bank_err_o, 1'b0);
    step();
    idle();
    #1;
    chk("bad_err1", bank_err_o, 1'b1);
    step();

    // counter saturation then clear during a conflict
    for (int a = 0; a < 4; a++) drv(a, 1'b1, 12'(a), 4'b0001, 32'h0);
    repeat (65541) step();
    #1;
    chk("cnt_sat", conflict_cnt_o, 16'hFFFF);
    cnt_clear_i = 1'b1;
    step();
    cnt_clear_i = 1'b0;
    #1;
    chk("cnt_clr", conflict_cnt_o, 16'h0000);
    idle();
    repeat (3) step();

    // reset with loads in flight
    for (int a = 0; a < 4; a++) drv(a, 1'b1, 12'h030, 4'b0001 << a, 32'h0);
    step();
    idle();
    rst_i = 1'b1;
    #1;
    chk("mid_req", bank_req_o, 4'h0);
    chk("mid_rvalid", age_rvalid_o, 4'h0);
    chk("mid_cnt", conflict_cnt_o, 16'h0);
    chk("mid_err", bank_err_o, 1'b0);
    chk("mid_addr", bank_addr_o, 48'h0);
    step();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      chk("late_rvalid", age_rvalid_o, 4'h0);
    end
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
